// File: rtl/spu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spu_pkg
// Description : Shared types and constants for the SPU dual-issue control
//               stage: pipe encodings, buffer FSM states, the per-slot
//               instruction record and the hazard helper.
// Revision    : 1.0 - initial release
// ============================================================================
package spu_pkg;

    localparam int SPU_REGW = 7;
    localparam int SPU_LATW = 4;

    localparam logic PIPE_EVEN = 1'b0;
    localparam logic PIPE_ODD  = 1'b1;

    localparam logic [6:0] NOP_ID = 7'd0;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_PAIR   = 2'd1,
        ST_B_ONLY = 2'd2
    } buf_state_t;

    // Fields forwarded verbatim to the register-file / FU pipe wrapper.
    typedef struct packed {
        logic [31:0]         full_instr;
        logic [6:0]          instr_id;
        logic [SPU_REGW-1:0] reg_dst;
        logic [2:0]          unit_id;
        logic [SPU_LATW-1:0] latency;
        logic                reg_wr;
        logic [6:0]          imme7;
        logic [9:0]          imme10;
        logic [15:0]         imme16;
        logic [17:0]         imme18;
        logic [SPU_REGW-1:0] ra_addr;
        logic [SPU_REGW-1:0] rb_addr;
        logic [SPU_REGW-1:0] rc_addr;
    } spu_out_t;

    // Complete decoded slot: issue-control-only fields plus the forwarded part.
    typedef struct packed {
        logic     valid;
        logic     pipe;
        logic     ra_use;
        logic     rb_use;
        logic     rc_use;
        spu_out_t f;
    } issue_slot_t;

    // A source becomes readable in the cycle its counter is at 1: the wrapper
    // reads the register file one cycle after issue, by which time the
    // producer has written back. This makes a consumer of a latency-L
    // producer issue exactly L cycles after it.
    // A second writer may go once the older result lands no later than its own.
    function automatic logic hazard(
        input logic                ra_use,
        input logic                rb_use,
        input logic                rc_use,
        input logic                reg_wr,
        input logic [SPU_LATW-1:0] lat,
        input logic [SPU_LATW-1:0] sb_ra,
        input logic [SPU_LATW-1:0] sb_rb,
        input logic [SPU_LATW-1:0] sb_rc,
        input logic [SPU_LATW-1:0] sb_dst
    );
        return (ra_use && (sb_ra > SPU_LATW'(1))) ||
               (rb_use && (sb_rb > SPU_LATW'(1))) ||
               (rc_use && (sb_rc > SPU_LATW'(1))) ||
               (reg_wr && (sb_dst > lat));
    endfunction

endpackage
`default_nettype wire

// File: rtl/spu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : spu_issue_ctrl_if
// Description : Decoded-pair handshake into the issue stage and the even/odd
//               instruction bundles it drives towards the pipe wrapper.
//               master : decoder / wrapper side, slave : issue control.
//               in_valid, in_ready : pair handshake
//               a, b               : slot A (older) and slot B
//               even, odd          : registered per-pipe issue bundles
// Revision    : 1.0 - initial release
// ============================================================================
interface spu_issue_ctrl_if;
    import spu_pkg::*;

    logic        in_valid;
    logic        in_ready;
    issue_slot_t a;
    issue_slot_t b;
    spu_out_t    even;
    spu_out_t    odd;

    modport master (output in_valid, a, b, input in_ready, even, odd);
    modport slave  (input in_valid, a, b, output in_ready, even, odd);
endinterface
`default_nettype wire

// File: rtl/spu_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : spu_scoreboard
// Description : Per-register remaining-latency counters. Each nonzero counter
//               counts down every cycle; a set port loads a new latency,
//               overriding the count-down.
//               clk, rst           : clock, async active-low reset
//               set_en/addr/lat[2] : one set port per issue slot
//               rd_addr/rd_val[NRD]: combinational read ports
// Revision    : 1.0 - initial release
// ============================================================================
module spu_scoreboard #(
    parameter int NREG = 128,
    parameter int LATW = 4,
    parameter int NRD  = 8,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                set_en,
    input  logic [1:0][AW-1:0]        set_addr,
    input  logic [1:0][LATW-1:0]      set_lat,
    input  logic [NRD-1:0][AW-1:0]    rd_addr,
    output logic [NRD-1:0][LATW-1:0]  rd_val
);

    logic [LATW-1:0] cnt [NREG];

    // Issue logic never sets the same register from both ports in one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (set_en[0] && (set_addr[0] == AW'(r)))
                    cnt[r] <= set_lat[0];
                else if (set_en[1] && (set_addr[1] == AW'(r)))
                    cnt[r] <= set_lat[1];
                else if (cnt[r] != '0)
                    cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

    generate
        for (genvar i = 0; i < NRD; i++) begin : g_rd
            assign rd_val[i] = cnt[rd_addr[i]];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/spu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spu_issue_ctrl
// Description : Dual-issue control stage. Buffers one decoded pair, checks
//               RAW/WAW/structural hazards against the latency scoreboard
//               and issues in order, at most one instruction per pipe.
//               clk       : clock
//               rst       : asynchronous active-low reset
//               flush     : drop the buffered pair (scoreboard kept)
//               bus       : pair handshake in, even/odd bundles out
//               stall_cnt : saturating count of non-empty, no-issue cycles
// Revision    : 1.0 - initial release
// ============================================================================
module spu_issue_ctrl
    import spu_pkg::*;
#(
    parameter int NREG = 128,
    parameter int LATW = SPU_LATW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    spu_issue_ctrl_if.slave   bus,
    output logic [15:0]       stall_cnt
);

    localparam int AW  = $clog2(NREG);
    localparam int NRD = 8;

    buf_state_t  state, state_nxt;
    issue_slot_t slot_a, slot_b;
    logic        issue_a, issue_b, a_blk, b_blk, b_dep, ready, accept;
    spu_out_t    even_nxt, odd_nxt;

    logic [NRD-1:0][AW-1:0]   rd_addr;
    logic [NRD-1:0][LATW-1:0] rd_val;
    logic [1:0]               set_en;
    logic [1:0][AW-1:0]       set_addr;
    logic [1:0][LATW-1:0]     set_lat;

    // Read ports 0..3 serve slot A, 4..7 slot B (ra, rb, rc, dst).
    assign rd_addr = {slot_b.f.reg_dst, slot_b.f.rc_addr, slot_b.f.rb_addr, slot_b.f.ra_addr,
                      slot_a.f.reg_dst, slot_a.f.rc_addr, slot_a.f.rb_addr, slot_a.f.ra_addr};

    assign a_blk = hazard(slot_a.ra_use, slot_a.rb_use, slot_a.rc_use, slot_a.f.reg_wr,
                          slot_a.f.latency, rd_val[0], rd_val[1], rd_val[2], rd_val[3]);
    assign b_blk = hazard(slot_b.ra_use, slot_b.rb_use, slot_b.rc_use, slot_b.f.reg_wr,
                          slot_b.f.latency, rd_val[4], rd_val[5], rd_val[6], rd_val[7]);

    // B touches A's destination: the scoreboard cannot see A yet, so split.
    assign b_dep = slot_a.f.reg_wr &&
                   ((slot_b.ra_use && (slot_b.f.ra_addr == slot_a.f.reg_dst)) ||
                    (slot_b.rb_use && (slot_b.f.rb_addr == slot_a.f.reg_dst)) ||
                    (slot_b.rc_use && (slot_b.f.rc_addr == slot_a.f.reg_dst)) ||
                    (slot_b.f.reg_wr && (slot_b.f.reg_dst == slot_a.f.reg_dst)));

    always_comb begin
        state_nxt = state;
        issue_a   = 1'b0;
        issue_b   = 1'b0;
        ready     = 1'b0;
        case (state)
            ST_EMPTY: begin
                ready = 1'b1;
            end
            ST_PAIR: begin
                if (slot_a.valid && !a_blk) begin
                    issue_a = 1'b1;
                    if (slot_b.valid && !b_blk && (slot_b.pipe != slot_a.pipe) && !b_dep) begin
                        issue_b   = 1'b1;
                        ready     = 1'b1;
                        state_nxt = ST_EMPTY;
                    end else begin
                        state_nxt = ST_B_ONLY;
                    end
                end
            end
            ST_B_ONLY: begin
                if (slot_b.valid && !b_blk) begin
                    issue_b   = 1'b1;
                    ready     = 1'b1;
                    state_nxt = ST_EMPTY;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase

        if (flush) begin
            issue_a   = 1'b0;
            issue_b   = 1'b0;
            state_nxt = ST_EMPTY;
        end

        accept = bus.in_valid && ready && !flush;
        if (accept) begin
            if (bus.a.valid && bus.b.valid)
                state_nxt = ST_PAIR;
            else if (bus.a.valid || bus.b.valid)
                state_nxt = ST_B_ONLY;
        end
    end

    assign bus.in_ready = ready;

    always_comb begin
        even_nxt = '0;
        odd_nxt  = '0;
        if (issue_a) begin
            if (slot_a.pipe == PIPE_EVEN) even_nxt = slot_a.f;
            else                          odd_nxt  = slot_a.f;
        end
        if (issue_b) begin
            if (slot_b.pipe == PIPE_EVEN) even_nxt = slot_b.f;
            else                          odd_nxt  = slot_b.f;
        end
    end

    assign set_en   = {issue_b && slot_b.f.reg_wr, issue_a && slot_a.f.reg_wr};
    assign set_addr = {slot_b.f.reg_dst, slot_a.f.reg_dst};
    assign set_lat  = {slot_b.f.latency, slot_a.f.latency};

    spu_scoreboard #(.NREG(NREG), .LATW(LATW), .NRD(NRD)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (set_en),
        .set_addr (set_addr),
        .set_lat  (set_lat),
        .rd_addr  (rd_addr),
        .rd_val   (rd_val)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_EMPTY;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_a    <= '0;
            slot_b    <= '0;
            bus.even  <= '0;
            bus.odd   <= '0;
            stall_cnt <= '0;
        end else begin
            // A lone valid slot always sits in slot B, the pending position.
            if (accept) begin
                slot_a <= bus.a;
                slot_b <= bus.b.valid ? bus.b : bus.a;
            end
            bus.even <= even_nxt;
            bus.odd  <= odd_nxt;
            if ((state != ST_EMPTY) && !issue_a && !issue_b && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule
`default_nettype wire
